instr_fetch_issue_unit: RTL and testbench

- Producer side of the opcode/control interface in the single-cycle RISC-V core.
- Fetches 32-bit instructions from instruction memory over a req/valid handshake and presents Instruction_Opcode to the Control Unit.
- Takes back the Control Unit's Branch decision plus the ALU Zero flag and computes the next PC.
- Halts on unsupported opcodes and counts issued instructions.

---
 rtl/instr_fetch_issue_unit.sv | 140 ++++++++++++++
 tb/tb_instr_fetch_issue_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_issue_unit.sv
// Fetch/issue front end for the single-cycle RISC-V core: fetches over a req/valid
// handshake, issues the opcode to the Control Unit and steps the PC from its decision.
module instr_fetch_issue_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_valid,
    input  logic [31:0]           imem_rdata,
    input  logic                  Branch,
    input  logic                  Zero,
    input  logic [ADDR_WIDTH-1:0] Branch_Offset,
    output logic [31:0]           Instruction,
    output logic [6:0]            Instruction_Opcode,
    output logic                  Instr_Valid,
    output logic [ADDR_WIDTH-1:0] PC_Out,
    output logic                  Halted,
    output logic                  Misaligned,
    output logic [CNT_WIDTH-1:0]  Instr_Count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    // R-type, load, store, branch
    localparam int NUM_OPS = 4;
    localparam logic [NUM_OPS*7-1:0] SUPPORTED_OPS = {7'b1100011, 7'b0100011,
                                                      7'b0000011, 7'b0110011};

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
    logic [31:0]           instr_reg, instr_next;
    logic [CNT_WIDTH-1:0]  count_reg, count_next;
    logic                  halted_reg, halted_next;
    logic                  misaligned_reg, misaligned_next;

    logic [NUM_OPS-1:0]    op_match;
    logic                  op_supported;
    logic                  branch_taken;
    logic                  offset_aligned;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] pc_branch;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPS; gi = gi + 1) begin : g_op_match
            assign op_match[gi] = (instr_reg[6:0] == SUPPORTED_OPS[gi*7 +: 7]);
        end
    endgenerate

    assign op_supported   = |op_match;
    assign branch_taken   = Branch & Zero;
    assign offset_aligned = (Branch_Offset[1:0] == 2'b00);
    // Both adds wrap modulo 2^ADDR_WIDTH; negative offsets are plain two's complement
    assign pc_plus4       = pc_reg + ADDR_WIDTH'(4);
    assign pc_branch      = pc_reg + Branch_Offset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            instr_reg      <= '0;
            count_reg      <= '0;
            halted_reg     <= 1'b0;
            misaligned_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            instr_reg      <= instr_next;
            count_reg      <= count_next;
            halted_reg     <= halted_next;
            misaligned_reg <= misaligned_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        instr_next      = instr_reg;
        count_next      = count_reg;
        halted_next     = halted_reg;
        misaligned_next = misaligned_reg;

        unique case (state_reg)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (imem_valid) begin
                    instr_next = imem_rdata;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // An unsupported opcode halts even while stalled: it is issued for exactly one cycle
                if (!op_supported) begin
                    state_next  = HALT;
                    halted_next = 1'b1;
                end else if (!stall) begin
                    state_next = FETCH;
                    count_next = count_reg + CNT_WIDTH'(1);
                    if (branch_taken && offset_aligned) begin
                        pc_next = pc_branch;
                    end else begin
                        pc_next = pc_plus4;
                        if (branch_taken) begin
                            misaligned_next = 1'b1;
                        end
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign imem_req           = (state_reg == FETCH);
    assign imem_addr          = pc_reg;
    assign Instruction        = instr_reg;
    assign Instruction_Opcode = instr_reg[6:0];
    assign Instr_Valid        = (state_reg == ISSUE);
    assign PC_Out             = pc_reg;
    assign Halted             = halted_reg;
    assign Misaligned         = misaligned_reg;
    assign Instr_Count        = count_reg;

endmodule

// File: tb/tb_instr_fetch_issue_unit.sv
// Directed bench for instr_fetch_issue_unit: hand-computed PC/count/flag values
// checked with immediate assertions after each step.
module tb_instr_fetch_issue_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        Branch;
    logic        Zero;
    logic [31:0] Branch_Offset;
    logic [31:0] Instruction;
    logic [6:0]  Instruction_Opcode;
    logic        Instr_Valid;
    logic [31:0] PC_Out;
    logic        Halted;
    logic        Misaligned;
    logic [15:0] Instr_Count;

    int vectors = 0;
    int miscompares = 0;

    instr_fetch_issue_unit #(
        .ADDR_WIDTH(32),
        .RESET_PC  (32'h0),
        .CNT_WIDTH (16)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_valid        (imem_valid),
        .imem_rdata        (imem_rdata),
        .Branch            (Branch),
        .Zero              (Zero),
        .Branch_Offset     (Branch_Offset),
        .Instruction       (Instruction),
        .Instruction_Opcode(Instruction_Opcode),
        .Instr_Valid       (Instr_Valid),
        .PC_Out            (PC_Out),
        .Halted            (Halted),
        .Misaligned        (Misaligned),
        .Instr_Count       (Instr_Count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered in FETCH, leaves in FETCH (or wherever the instruction leads) after one issue
    task automatic issue_one(input string tag, input logic [31:0] rdata, input logic br,
                             input logic zr, input logic [31:0] off,
                             input logic [31:0] exp_pc, input logic [15:0] exp_cnt);
        check({tag, "_req"}, 32'(imem_req), 32'd1);
        imem_valid = 1'b1;
        imem_rdata = rdata;
        step();
        imem_valid    = 1'b0;
        Branch        = br;
        Zero          = zr;
        Branch_Offset = off;
        check({tag, "_ivalid"}, 32'(Instr_Valid), 32'd1);
        check({tag, "_opcode"}, 32'(Instruction_Opcode), 32'(rdata[6:0]));
        step();
        Branch = 1'b0;
        Zero   = 1'b0;
        check({tag, "_pc"}, PC_Out, exp_pc);
        check({tag, "_cnt"}, 32'(Instr_Count), 32'(exp_cnt));
        $display("txn %s: instr=%h pc=%h count=%0d", tag, rdata, PC_Out, Instr_Count);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
        Branch = 1'b0; Zero = 1'b0; Branch_Offset = '0;
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", Instruction, 32'h0);
        check("rst_opcode", 32'(Instruction_Opcode), 32'h0);
        check("rst_ivalid", 32'(Instr_Valid), 32'd0);
        check("rst_halted", 32'(Halted), 32'd0);
        check("rst_misal", 32'(Misaligned), 32'd0);
        check("rst_cnt", 32'(Instr_Count), 32'd0);
        step();
        step();

        // 1: first fetch with same-cycle valid
        reset = 1'b1;
        check("idle_req", 32'(imem_req), 32'd0);
        step();
        check("t1_addr", imem_addr, 32'h0);
        issue_one("t1", 32'h00000033, 1'b0, 1'b0, 32'h0, 32'd4, 16'd1);
        check("t1_req_after", 32'(imem_req), 32'd1);
        check("t1_addr_after", imem_addr, 32'd4);

        // 2: walk PC to 16, taken backward branch, back to 16, untaken branch
        issue_one("p8",  32'h00000033, 1'b0, 1'b0, 32'h0, 32'd8,  16'd2);
        issue_one("p12", 32'h00000033, 1'b0, 1'b0, 32'h0, 32'd12, 16'd3);
        issue_one("p16", 32'h00000033, 1'b0, 1'b0, 32'h0, 32'd16, 16'd4);
        issue_one("t2_taken", 32'h00000063, 1'b1, 1'b1, 32'hFFFFFFF8, 32'd8, 16'd5);
        issue_one("p12b", 32'h00000033, 1'b0, 1'b0, 32'h0, 32'd12, 16'd6);
        issue_one("p16b", 32'h00000033, 1'b0, 1'b0, 32'h0, 32'd16, 16'd7);
        issue_one("t2_untaken", 32'h00000063, 1'b1, 1'b0, 32'hFFFFFFF8, 32'd20, 16'd8);

        // 3: delayed valid, then two stalled ISSUE cycles with a taken branch pending
        for (int i = 0; i < 3; i++) begin
            check("t3_wait_req", 32'(imem_req), 32'd1);
            check("t3_wait_addr", imem_addr, 32'd20);
            step();
        end
        imem_valid = 1'b1;
        imem_rdata = 32'h00002003;
        check("t3_valid_addr", imem_addr, 32'd20);
        step();
        imem_valid = 1'b0;
        stall = 1'b1; Branch = 1'b1; Zero = 1'b1; Branch_Offset = 32'd8;
        check("t3_iv1", 32'(Instr_Valid), 32'd1);
        step();
        check("t3_iv2", 32'(Instr_Valid), 32'd1);
        check("t3_pc_stall", PC_Out, 32'd20);
        check("t3_cnt_stall", 32'(Instr_Count), 32'd8);
        step();
        check("t3_iv3", 32'(Instr_Valid), 32'd1);
        check("t3_pc_stall2", PC_Out, 32'd20);
        stall = 1'b0; Branch = 1'b0; Zero = 1'b0;
        step();
        check("t3_pc", PC_Out, 32'd24);
        check("t3_cnt", 32'(Instr_Count), 32'd9);
        check("t3_iv_off", 32'(Instr_Valid), 32'd0);
        $display("txn t3: stalled load pc=%h count=%0d", PC_Out, Instr_Count);

        // 5: misaligned taken branch, then jump to the top of memory and wrap
        check("t5_misal_pre", 32'(Misaligned), 32'd0);
        issue_one("t5_misal", 32'h00000063, 1'b1, 1'b1, 32'd6, 32'd28, 16'd10);
        check("t5_misal_set", 32'(Misaligned), 32'd1);
        issue_one("t5_top", 32'h00000063, 1'b1, 1'b1, 32'hFFFFFFE0, 32'hFFFFFFFC, 16'd11);
        check("t5_misal_sticky", 32'(Misaligned), 32'd1);
        issue_one("t5_wrap", 32'h00000063, 1'b1, 1'b0, 32'd8, 32'd0, 16'd12);
        issue_one("p4", 32'h00000023, 1'b0, 1'b0, 32'h0, 32'd4, 16'd13);

        // 4: unsupported opcode halts
        imem_valid = 1'b1;
        imem_rdata = 32'h0000006F;
        step();
        imem_valid = 1'b0;
        check("t4_ivalid", 32'(Instr_Valid), 32'd1);
        check("t4_halted_pre", 32'(Halted), 32'd0);
        step();
        check("t4_halted", 32'(Halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            stall = i[0];
            imem_valid = 1'b1;
            check("t4_req", 32'(imem_req), 32'd0);
            check("t4_iv", 32'(Instr_Valid), 32'd0);
            step();
        end
        stall = 1'b0; imem_valid = 1'b0;
        check("t4_pc", PC_Out, 32'd4);
        check("t4_cnt", 32'(Instr_Count), 32'd13);
        check("t4_halted_hold", 32'(Halted), 32'd1);
        $display("txn t4: halted pc=%h count=%0d", PC_Out, Instr_Count);
        #2 reset = 1'b0;
        #1;
        check("t4_rst_halted", 32'(Halted), 32'd0);
        check("t4_rst_pc", PC_Out, 32'd0);
        check("t4_rst_misal", 32'(Misaligned), 32'd0);
        check("t4_rst_cnt", 32'(Instr_Count), 32'd0);
        step();

        // 6: reset during FETCH coinciding with valid data
        reset = 1'b1;
        step();
        issue_one("t6_pre", 32'h00000033, 1'b0, 1'b0, 32'h0, 32'd4, 16'd1);
        imem_valid = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        #2 reset = 1'b0;
        #1;
        check("t6_req", 32'(imem_req), 32'd0);
        check("t6_addr", imem_addr, 32'd0);
        check("t6_instr", Instruction, 32'h0);
        check("t6_cnt", 32'(Instr_Count), 32'd0);
        check("t6_ivalid", 32'(Instr_Valid), 32'd0);
        step();
        reset = 1'b1;
        check("t6_idle_req", 32'(imem_req), 32'd0);
        step();
        imem_valid = 1'b0;
        check("t6_stale_instr", Instruction, 32'h0);
        check("t6_fetch_addr", imem_addr, 32'd0);
        step();
        check("t6_wait_instr", Instruction, 32'h0);
        issue_one("t6_post", 32'h00000003, 1'b0, 1'b0, 32'h0, 32'd4, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
